// File: rtl/portal_indication_arbiter.sv
// portal_indication_arbiter: round-robin share of NCHAN indication FIFO heads onto one portal output, whole messages at a time; `define INTR_MASK_EN adds a writable interrupt mask.
// Latency: grant 1 cycle after data appears in IDLE; head/deq pass through combinationally while granted; interrupts lag chan_notEmpty by 1 cycle.
// Backpressure: out_deq reaches only the granted channel and only while its head is valid; an empty granted FIFO holds the grant until the message completes.
module portal_indication_arbiter #(
  parameter int NCHAN = 4,
  parameter int DW    = 32,
  parameter int SZW   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCHAN-1:0]     chan_notEmpty,
  input  logic [NCHAN*DW-1:0]  chan_first,
  input  logic [NCHAN*SZW-1:0] chan_size,
  output logic [NCHAN-1:0]     chan_deq,
  output logic                 out_notEmpty,
  output logic [DW-1:0]        out_first,
  input  logic                 out_deq,
`ifdef INTR_MASK_EN
  input  logic                 mask_we,
  input  logic [NCHAN-1:0]     mask_wdata,
`endif
  output logic [3:0]           out_channel,
  output logic                 out_busy,
  output logic                 intr_status,
  output logic [31:0]          intr_channel
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state;
  logic [CW-1:0]  grant;
  logic [CW-1:0]  rr_ptr;
  logic [CW-1:0]  pick_idx;
  logic           pick_vld;
  logic [SZW-1:0] count;
  logic [NCHAN-1:0] mask;
  logic [NCHAN-1:0] pending;
  logic [NCHAN-1:0] rot;
  logic [31:0]    low_chan;
  logic           accept;
  logic [DW-1:0]  first_arr [NCHAN];
  logic [SZW-1:0] size_arr  [NCHAN];

  for (genvar i = 0; i < NCHAN; i++) begin : g_unpack
    assign first_arr[i] = chan_first[i*DW +: DW];
    assign size_arr[i]  = chan_size[i*SZW +: SZW];
  end

  // Rotate requests so bit 0 is the channel at rr_ptr; first set bit wins.
  assign rot = NCHAN'({chan_notEmpty, chan_notEmpty} >> rr_ptr);

  always_comb begin
    int s;
    s        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (!pick_vld && rot[k]) begin
        pick_vld = 1'b1;
        s = int'(rr_ptr) + k;
        if (s >= NCHAN) s = s - NCHAN;
        pick_idx = CW'(s);
      end
    end
  end

  assign out_busy     = (state == BUSY);
  assign out_notEmpty = out_busy && chan_notEmpty[grant];
  assign out_first    = out_busy ? first_arr[grant] : '0;
  assign out_channel  = 4'(grant);
  assign accept       = out_deq && out_notEmpty;

  always_comb begin
    chan_deq = '0;
    if (accept) chan_deq[grant] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick_idx;
            count <= (size_arr[pick_idx] == '0) ? SZW'(1) : size_arr[pick_idx];
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            count <= count - 1'b1;
            if (count == SZW'(1)) begin
              state  <= IDLE;
              rr_ptr <= (grant == CW'(NCHAN - 1)) ? '0 : grant + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INTR_MASK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          mask <= '0;
    else if (mask_we) mask <= mask_wdata;
  end
`else
  assign mask = '0;
`endif

  always_comb begin
    pending  = chan_notEmpty & ~mask;
    low_chan = '0;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      if (pending[k]) low_chan = 32'(k + 1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      intr_status  <= 1'b0;
      intr_channel <= '0;
    end else begin
      intr_status  <= |pending;
      intr_channel <= low_chan;
    end
  end
endmodule

// File: tb/tb_portal_indication_arbiter.sv
// Bench for portal_indication_arbiter: queue-backed channel FIFOs, a message-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_portal_indication_arbiter;
  localparam int NCHAN = 4;
  localparam int DW    = 32;
  localparam int SZW   = 16;

  logic                 clk, rst;
  logic [NCHAN-1:0]     chan_notEmpty, chan_deq;
  logic [NCHAN*DW-1:0]  chan_first;
  logic [NCHAN*SZW-1:0] chan_size;
  logic                 out_notEmpty, out_deq, out_busy, intr_status;
  logic [DW-1:0]        out_first;
  logic [3:0]           out_channel;
  logic [31:0]          intr_channel;
  logic                 mask_we;
  logic [NCHAN-1:0]     mask_wdata;

  portal_indication_arbiter #(.NCHAN(NCHAN), .DW(DW), .SZW(SZW)) dut (
    .CLK(clk), .RST(rst),
    .chan_notEmpty(chan_notEmpty), .chan_first(chan_first), .chan_size(chan_size),
    .chan_deq(chan_deq), .out_notEmpty(out_notEmpty), .out_first(out_first),
    .out_deq(out_deq),
`ifdef INTR_MASK_EN
    .mask_we(mask_we), .mask_wdata(mask_wdata),
`endif
    .out_channel(out_channel), .out_busy(out_busy),
    .intr_status(intr_status), .intr_channel(intr_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]  q [NCHAN][$];
  logic [SZW-1:0] sz [NCHAN];
  logic           deq_req;

  bit             m_busy = 1'b0;
  int             m_grant = 0, m_rr = 0, m_rem = 0;
  logic           m_istat = 1'b0;
  logic [31:0]    m_ichan = '0;
  logic [NCHAN-1:0] m_mask = '0;

  int   n_pass = 0, n_total = 0;
  bit   chk_on = 1'b0;
  logic prev_busy = 1'b0;
  logic [31:0] grant_log[$], word_log[$], exp_log[$];
  int   deq_cnt [NCHAN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NCHAN; i++) if (q[i].size() > 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive();
    for (int i = 0; i < NCHAN; i++) begin
      chan_notEmpty[i]        = (q[i].size() > 0);
      chan_first[i*DW +: DW]  = (q[i].size() > 0) ? q[i][0] : '0;
      chan_size[i*SZW +: SZW] = sz[i];
    end
    out_deq = deq_req;
  endtask

  task automatic push(input int ch, input logic [DW-1:0] w);
    q[ch].push_back(w);
    drive();
  endtask

  // Message-level reference: whole messages are granted round-robin from the pointer.
  task automatic model_edge();
    logic [NCHAN-1:0] pend;
    bit found;
    int idx;
    if (rst) begin
      m_busy = 1'b0; m_grant = 0; m_rr = 0; m_rem = 0;
      m_istat = 1'b0; m_ichan = '0; m_mask = '0;
    end else begin
      pend = '0;
      for (int i = 0; i < NCHAN; i++) pend[i] = (q[i].size() > 0) && !m_mask[i];
      m_istat = |pend;
      m_ichan = '0;
      for (int i = NCHAN - 1; i >= 0; i--) if (pend[i]) m_ichan = 32'(i + 1);
      if (mask_we) m_mask = mask_wdata;
      if (m_busy) begin
        if (deq_req && q[m_grant].size() > 0) begin
          void'(q[m_grant].pop_front());
          m_rem--;
          if (m_rem == 0) begin
            m_busy = 1'b0;
            m_rr = (m_grant + 1) % NCHAN;
          end
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < NCHAN; k++) begin
          idx = (m_rr + k) % NCHAN;
          if (!found && q[idx].size() > 0) begin
            found = 1'b1;
            m_grant = idx;
            m_busy = 1'b1;
            m_rem = (sz[idx] == 0) ? 1 : int'(sz[idx]);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    drive();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((m_busy || !all_empty()) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      n_total++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
    settle();
    check({name, "_idle"}, 32'(out_busy), 32'd0);
  endtask

  task automatic check_seq(input string name, input bit use_words);
    int n;
    logic [31:0] a;
    n = use_words ? word_log.size() : grant_log.size();
    check({name, "_len"}, 32'(n), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < n) a = use_words ? word_log[i] : grant_log[i];
      else a = 32'hDEADBEEF;
      check($sformatf("%s_%0d", name, i), a, exp_log[i]);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 32'(out_busy), 32'd0);
    check({name, "_notEmpty"}, 32'(out_notEmpty), 32'd0);
    check({name, "_first"}, out_first, 32'd0);
    check({name, "_deq"}, 32'(chan_deq), 32'd0);
    check({name, "_channel"}, 32'(out_channel), 32'd0);
    check({name, "_intr_status"}, 32'(intr_status), 32'd0);
    check({name, "_intr_channel"}, intr_channel, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; deq_req = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    for (int i = 0; i < NCHAN; i++) begin
      q[i].delete();
      sz[i] = SZW'(1);
    end
    drive();
    step(); step(); settle();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    grant_log.delete();
    word_log.delete();
    for (int i = 0; i < NCHAN; i++) deq_cnt[i] = 0;
  endtask

  // Per-cycle compare against the model, plus logs for the directed checks.
  always @(negedge clk) begin
    logic exp_ne;
    logic [NCHAN-1:0] exp_deq;
    if (!rst) begin
      if (out_busy && !prev_busy) grant_log.push_back(32'(out_channel));
      if (out_notEmpty && out_deq) word_log.push_back(out_first);
      for (int i = 0; i < NCHAN; i++) if (chan_deq[i]) deq_cnt[i]++;
    end
    prev_busy = out_busy;
    if (!rst && chk_on) begin
      exp_ne  = m_busy && (q[m_grant].size() > 0);
      exp_deq = (exp_ne && deq_req) ? (NCHAN'(1) << m_grant) : '0;
      check("cyc_busy", 32'(out_busy), 32'(m_busy));
      check("cyc_notEmpty", 32'(out_notEmpty), 32'(exp_ne));
      if (exp_ne) check("cyc_first", out_first, q[m_grant][0]);
      if (m_busy) check("cyc_channel", 32'(out_channel), 32'(m_grant));
      check("cyc_deq", 32'(chan_deq), 32'(exp_deq));
      check("cyc_intr_status", 32'(intr_status), 32'(m_istat));
      check("cyc_intr_channel", intr_channel, m_ichan);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; deq_req = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    for (int i = 0; i < NCHAN; i++) begin
      sz[i] = SZW'(1);
      deq_cnt[i] = 0;
    end
    drive();
    do_reset();
    chk_on = 1'b1;

    // T1: single 3-word message on ch2, then round-robin pointer lands on 3
    sz[2] = SZW'(3);
    push(2, 32'hA0); push(2, 32'hA1); push(2, 32'hA2);
    settle();
    check("t1_idle_cycle", 32'(out_busy), 32'd0);
    step(); settle();
    check("t1_grant_busy", 32'(out_busy), 32'd1);
    check("t1_grant_ch", 32'(out_channel), 32'd2);
    deq_req = 1'b1; drive();
    step(); step(); step(); settle();
    check("t1_done_idle", 32'(out_busy), 32'd0);
    check("t1_deq_count", 32'(deq_cnt[2]), 32'd3);
    push(0, 32'hB0); push(3, 32'hB3);
    step(); settle();
    check("t1_rr_ptr3", 32'(out_channel), 32'd3);
    drain("t1");

    // T2: round robin across ch0 (two messages), ch1, ch3 (size 0 counts as 1)
    do_reset();
    deq_req = 1'b1; sz[3] = '0;
    push(0, 32'h00); push(0, 32'h01); push(1, 32'h10); push(3, 32'h30);
    drain("t2");
    exp_log = '{32'd0, 32'd1, 32'd3, 32'd0};
    check_seq("t2_grants", 1'b0);
    exp_log = '{32'h00, 32'h10, 32'h30, 32'h01};
    check_seq("t2_words", 1'b1);

    // T3: ch0 arrives mid-message; ch1 size change after grant is ignored
    do_reset();
    deq_req = 1'b1; sz[1] = SZW'(4);
    push(1, 32'h11); push(1, 32'h12); push(1, 32'h13); push(1, 32'h14);
    step(); step();
    sz[1] = SZW'(1);
    push(0, 32'h05);
    drain("t3");
    exp_log = '{32'd1, 32'd0};
    check_seq("t3_grants", 1'b0);
    exp_log = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h05};
    check_seq("t3_words", 1'b1);

    // T4: granted FIFO runs dry after 2 of 4 words
    do_reset();
    deq_req = 1'b1; sz[2] = SZW'(4);
    push(2, 32'h21); push(2, 32'h22);
    step(); step(); step(); step(); settle();
    check("t4_stall_busy", 32'(out_busy), 32'd1);
    check("t4_stall_notEmpty", 32'(out_notEmpty), 32'd0);
    check("t4_stall_deq", 32'(chan_deq), 32'd0);
    step(); step(); step(); settle();
    check("t4_still_busy", 32'(out_busy), 32'd1);
    check("t4_deq_count_stall", 32'(deq_cnt[2]), 32'd2);
    push(2, 32'h23); push(2, 32'h24);
    drain("t4");
    check("t4_deq_count_end", 32'(deq_cnt[2]), 32'd4);
    exp_log = '{32'h21, 32'h22, 32'h23, 32'h24};
    check_seq("t4_words", 1'b1);

    // T5: interrupts for ch2 and ch3 pending
    do_reset();
    push(2, 32'h2A); push(3, 32'h3A);
    settle();
    check("t5_lag_status", 32'(intr_status), 32'd0);
    step(); settle();
    check("t5_status", 32'(intr_status), 32'd1);
    check("t5_channel", intr_channel, 32'd3);
`ifdef INTR_MASK_EN
    mask_wdata = 4'b0100; mask_we = 1'b1;
    step();
    mask_we = 1'b0;
    settle();
    check("t5_mask_pending_ch", intr_channel, 32'd3);
    step(); settle();
    check("t5_masked_ch", intr_channel, 32'd4);
    check("t5_masked_arb", 32'(out_channel), 32'd2);
    mask_wdata = 4'b1100; mask_we = 1'b1;
    step();
    mask_we = 1'b0;
    step(); settle();
    check("t5_all_masked_status", 32'(intr_status), 32'd0);
    check("t5_all_masked_ch", intr_channel, 32'd0);
`endif

    // T6: asynchronous reset mid-message
    do_reset();
    deq_req = 1'b1;
    push(1, 32'h41);
    drain("t6a");
    sz[2] = SZW'(4); sz[0] = SZW'(1);
    push(2, 32'h51); push(2, 32'h52); push(2, 32'h53); push(2, 32'h54);
    push(0, 32'h50);
    step(); step(); step(); settle();
    check("t6_pre_channel", 32'(out_channel), 32'd2);
    check("t6_pre_words", 32'(word_log.size()), 32'd3);
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    step(); step(); settle();
    rst = 1'b0;
    word_log.delete();
    step(); settle();
    check("t6_regrant_busy", 32'(out_busy), 32'd1);
    check("t6_regrant_ch", 32'(out_channel), 32'd0);
    push(2, 32'h55); push(2, 32'h56);
    drain("t6b");
    exp_log = '{32'h50, 32'h53, 32'h54, 32'h55, 32'h56};
    check_seq("t6_words", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
